// File: rtl/shiftreg_univ.sv
// -----------------------------------------------------------------------------
// shiftreg_univ
//   Parametrised universal shift register: parallel load, single-step
//   shift/rotate, and counted burst shifting with a busy/done handshake.
//   The last bit shifted or rotated out is held in a registered serial output.
//
// Parameters
//   WIDTH   register width in bits (2 or more)
//   CW      width of the shift-count port, derived from WIDTH (do not override)
//
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   load    parallel load of d into q (aborts a running burst)
//   d       parallel load data
//   op      shift mode: 0 HOLD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 ASR, 6/7 HOLD
//   en      single shift of mode op this cycle (idle only)
//   sin     serial input bit for SHL/SHR
//   start   begin a burst of nshift shifts (idle only)
//   nshift  burst length, clamped to WIDTH
//   q       register contents
//   sout    last bit shifted/rotated out
//   busy    burst in progress
//   done    one-cycle pulse after the final burst shift
//   zero    (only with SHIFTREG_UNIV_ZERO_EN) registered "q is all zeros"
//
// Build option
//   SHIFTREG_UNIV_ZERO_EN  adds the registered zero-flag output port.
// -----------------------------------------------------------------------------
module shiftreg_univ #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       op,
  input  logic             en,
  input  logic             sin,
  input  logic             start,
  input  logic [CW-1:0]    nshift,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef SHIFTREG_UNIV_ZERO_EN
  ,
  output logic             zero
`endif
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_ASR  = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  localparam logic [CW-1:0] W_CNT = CW'(WIDTH);

  state_e           r_state;
  op_e              r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_done;

  op_e              w_step_op;
  logic             w_idle;
  logic             w_do_shift;
  logic [CW-1:0]    w_cnt_init;
  logic [WIDTH-1:0] w_shift_q;
  logic             w_shift_out;
  logic             w_shift_valid;
  logic [WIDTH-1:0] w_q_next;

  assign w_idle = (r_state == ST_IDLE);

  // A running burst uses the mode latched at start; op is only live when idle.
  assign w_step_op = w_idle ? op_e'(op) : r_op;

  // A shift happens on every burst step, or on an idle en that is not
  // pre-empted by load or start.
  assign w_do_shift = !load && (!w_idle || (!start && en));

  assign w_cnt_init = (nshift > W_CNT) ? W_CNT : nshift;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a value unassigned and infers a latch.
  always_comb begin
    w_shift_q     = r_q;
    w_shift_out   = 1'b0;
    w_shift_valid = 1'b0;
    case (w_step_op)
      OP_SHL: begin
        w_shift_q     = {r_q[WIDTH-2:0], sin};
        w_shift_out   = r_q[WIDTH-1];
        w_shift_valid = 1'b1;
      end
      OP_SHR: begin
        w_shift_q     = {sin, r_q[WIDTH-1:1]};
        w_shift_out   = r_q[0];
        w_shift_valid = 1'b1;
      end
      OP_ROL: begin
        w_shift_q     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_shift_out   = r_q[WIDTH-1];
        w_shift_valid = 1'b1;
      end
      OP_ROR: begin
        w_shift_q     = {r_q[0], r_q[WIDTH-1:1]};
        w_shift_out   = r_q[0];
        w_shift_valid = 1'b1;
      end
      OP_ASR: begin
        w_shift_q     = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_shift_out   = r_q[0];
        w_shift_valid = 1'b1;
      end
      default: ;  // HOLD and reserved modes leave q and sout alone
    endcase
  end

  always_comb begin
    w_q_next = r_q;
    if (load) begin
      w_q_next = d;
    end else if (w_do_shift) begin
      w_q_next = w_shift_q;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_HOLD;
      r_cnt   <= '0;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_q    <= w_q_next;
      if (w_do_shift && w_shift_valid) begin
        r_sout <= w_shift_out;
      end

      if (load) begin
        // Load aborts a burst silently: no done pulse.
        r_state <= ST_IDLE;
      end else if (!w_idle) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
      end else if (start) begin
        r_op  <= op_e'(op);
        r_cnt <= w_cnt_init;
        if (w_cnt_init == '0) begin
          // Zero-length burst completes immediately without entering SHIFT.
          r_done <= 1'b1;
        end else begin
          r_state <= ST_SHIFT;
        end
      end
    end
  end

  assign q    = r_q;
  assign sout = r_sout;
  assign busy = (r_state == ST_SHIFT);
  assign done = r_done;

`ifdef SHIFTREG_UNIV_ZERO_EN
  logic r_zero;

  // Flag tracks the value q takes at this edge, so it never lags q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zero <= 1'b1;
    end else begin
      r_zero <= (w_q_next == '0);
    end
  end

  assign zero = r_zero;
`endif

endmodule
